// File: rtl/present80_encrypt_iter_pkg.sv
// Shared PRESENT-80 constants and datapath helpers: S-box, bit permutation, key schedule.
package present_pkg;

    localparam int N_B  = 64;
    localparam int N_K  = 80;
    localparam int N_R  = 31;
    localparam int RC_W = 5;

    // S-box packed with entry 0 in the least significant nibble
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [N_B-1:0] player64(input logic [N_B-1:0] s);
        logic [N_B-1:0] p;
        p = '0;
        for (int i = 0; i < 63; i++) begin
            p[(16 * i) % 63] = s[i];
        end
        p[63] = s[63];
        return p;
    endfunction

    function automatic logic [N_K-1:0] key_schedule80(input logic [N_K-1:0] key,
                                                      input logic [RC_W-1:0] i);
        logic [N_K-1:0] t;
        t          = {key[18:0], key[79:19]};
        t[79:76]   = sbox4(t[79:76]);
        t[19:15]   = t[19:15] ^ i;
        return t;
    endfunction

endpackage

// File: rtl/present80_encrypt_iter_if.sv
// Host-side request/acknowledge bus for the PRESENT-80 core.
interface present80_encrypt_iter_if;
    // 4-phase handshake: host raises req with k/m valid and holds it until ack=1;
    // c is valid and stable while ack=1; ack drops on the edge that samples req=0.
    logic [79:0] k;
    logic [63:0] m;
    logic [63:0] c;
    logic        req;
    logic        ack;

    modport master (output k, m, req, input c, ack);
    modport slave  (input k, m, req, output c, ack);
endinterface

// File: rtl/present_round_logic.sv
// One full PRESENT round: add round key, 16 parallel S-boxes, bit permutation.
module present_round_logic
    import present_pkg::*;
(
    input  logic [N_B-1:0] s,
    input  logic [N_K-1:0] key,
    output logic [N_B-1:0] y
);
    logic [N_B-1:0] x;
    logic [N_B-1:0] sb;

    assign x = s ^ key[79:16];

    always_comb begin
        sb = '0;
        for (int i = 0; i < 16; i++) begin
            sb[4*i +: 4] = sbox4(x[4*i +: 4]);
        end
    end

    assign y = player64(sb);
endmodule

// File: rtl/present80_encrypt_iter.sv
// Iterative PRESENT-80 encryptor: load cycle plus 31 round cycles, result held until req drops.
module present80_encrypt_iter
    import present_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    present80_encrypt_iter_if.slave bus,
    output state_t                  fsm_state
);
    state_t          state;
    state_t          state_next;
    logic [N_B-1:0]  st;
    logic [N_B-1:0]  c_q;
    logic [N_B-1:0]  round_out;
    logic [N_K-1:0]  rk;
    logic [N_K-1:0]  rk_next;
    logic [RC_W-1:0] rc;
    logic            ack_q;
    logic            load;
    logic            last;
    logic            release_ack;

    present_round_logic u_round (.s(st), .key(rk), .y(round_out));

    assign rk_next = key_schedule80(rk, rc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load)        state_next = RUN;
            RUN:     if (last)        state_next = DONE;
            DONE:    if (release_ack) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_comb begin
        load        = 1'b0;
        last        = 1'b0;
        release_ack = 1'b0;
        case (state)
            IDLE:    load        = bus.req && !ack_q;
            RUN:     last        = (rc == RC_W'(N_R));
            DONE:    release_ack = !bus.req;
            default: ;
        endcase
    end

    // rc holds at 31 on the final edge so it never wraps inside RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= '0;
            rk    <= '0;
            rc    <= '0;
            c_q   <= '0;
            ack_q <= 1'b0;
        end else begin
            if (load) begin
                st <= bus.m;
                rk <= bus.k;
                rc <= RC_W'(1);
            end else if (state == RUN) begin
                st <= round_out;
                rk <= rk_next;
                if (last) begin
                    c_q   <= round_out ^ rk_next[79:16];
                    ack_q <= 1'b1;
                end else begin
                    rc <= rc + RC_W'(1);
                end
            end
            if (release_ack) ack_q <= 1'b0;
        end
    end

    assign bus.c     = c_q;
    assign bus.ack   = ack_q;
    assign fsm_state = state;
endmodule

// File: tb/tb_present80_encrypt_iter.sv
// Directed bench for the iterative PRESENT-80 core using published test vectors.
module tb_present80_encrypt_iter;
    import present_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t fsm_state;
    int     total;
    int     bad;
    int     n;

    present80_encrypt_iter_if bus_if ();

    present80_encrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if.slave),
        .fsm_state (fsm_state)
    );

    localparam logic [63:0] M0 = 64'h0000_0000_0000_0000;
    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] K0 = 80'h0;
    localparam logic [79:0] K1 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] C_T1 = 64'h5579_C138_7B22_8445;
    localparam logic [63:0] C_T2 = 64'hE72C_46C0_F594_5049;
    localparam logic [63:0] C_T3 = 64'hA112_FFC7_2F68_417B;
    localparam logic [63:0] C_T4 = 64'h3333_DCD3_2132_10D2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raise req with m/k and count edges until ack; optionally drop req after edge drop_at.
    task automatic run_to_ack(input logic [63:0] mv, input logic [79:0] kv,
                              input int drop_at, input int limit, output int edges);
        logic [63:0] c0;
        int          changes;
        bus_if.m   = mv;
        bus_if.k   = kv;
        bus_if.req = 1'b1;
        c0         = bus_if.c;
        changes    = 0;
        edges      = 0;
        while (edges < limit && bus_if.ack !== 1'b1) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus_if.ack !== 1'b1 && bus_if.c !== c0) changes++;
            if (edges == drop_at) bus_if.req = 1'b0;
        end
        check("c_stable_during_run", 64'(changes), 64'd0);
    endtask

    task automatic finish_hs(input string tag);
        bus_if.req = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ack_low"}, 64'(bus_if.ack), 64'd0);
        check({tag, "_idle"}, 64'(fsm_state), 64'(IDLE));
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        bus_if.req = 1'b0;
        bus_if.m   = '0;
        bus_if.k   = '0;
        #3;
        check("reset_ack", 64'(bus_if.ack), 64'd0);
        check("reset_c", bus_if.c, 64'd0);
        check("reset_state", 64'(fsm_state), 64'(IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1..T3: basic vectors with latency check
        run_to_ack(M0, K0, 0, 40, n);
        check("t1_latency", 64'(n), 64'd32);
        check("t1_ack", 64'(bus_if.ack), 64'd1);
        check("t1_c", bus_if.c, C_T1);
        finish_hs("t1");

        run_to_ack(M0, K1, 0, 40, n);
        check("t2_latency", 64'(n), 64'd32);
        check("t2_c", bus_if.c, C_T2);
        finish_hs("t2");

        run_to_ack(M1, K0, 0, 40, n);
        check("t3_latency", 64'(n), 64'd32);
        check("t3_c", bus_if.c, C_T3);
        finish_hs("t3");

        // T4: hold req in DONE and disturb m/k; c and ack must stay put
        run_to_ack(M1, K1, 0, 40, n);
        check("t4_latency", 64'(n), 64'd32);
        check("t4_c", bus_if.c, C_T4);
        bus_if.m = 64'h0123_4567_89AB_CDEF;
        bus_if.k = 80'h1234_5678_9ABC_DEF0_1357;
        repeat (3) @(posedge clk);
        #1;
        check("t4_hold_ack", 64'(bus_if.ack), 64'd1);
        check("t4_hold_c", bus_if.c, C_T4);
        check("t4_hold_state", 64'(fsm_state), 64'(DONE));
        finish_hs("t4");

        // T5: asynchronous reset during round 10 aborts the run
        run_to_ack(M0, K0, 0, 11, n);
        check("t5_no_early_ack", 64'(n), 64'd11);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_reset_ack", 64'(bus_if.ack), 64'd0);
        check("t5_reset_c", bus_if.c, 64'd0);
        check("t5_reset_state", 64'(fsm_state), 64'(IDLE));
        bus_if.req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_to_ack(M0, K1, 0, 40, n);
        check("t5_rerun_latency", 64'(n), 64'd32);
        check("t5_rerun_c", bus_if.c, C_T2);
        finish_hs("t5");

        // T6: req dropped at round 5, run still completes then ack falls
        run_to_ack(M0, K0, 6, 40, n);
        check("t6_latency", 64'(n), 64'd32);
        check("t6_c", bus_if.c, C_T1);
        @(posedge clk);
        #1;
        check("t6_ack_fall", 64'(bus_if.ack), 64'd0);
        check("t6_idle", 64'(fsm_state), 64'(IDLE));

        // New request right after ack falls starts a fresh run from IDLE
        run_to_ack(M1, K0, 0, 40, n);
        check("t6_restart_latency", 64'(n), 64'd32);
        check("t6_restart_c", bus_if.c, C_T3);
        finish_hs("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
